// File: rtl/cnn_cell_engine.sv
// cnn_cell_engine: time-multiplexed cellular neural network engine.
// Holds U, X and Y for a ROWS x COLS grid. It iterates the Euler-discretised
// cell equation x += dt*(-x + sum A*y + sum B*u + I). A single shared MAC
// walks each 3x3 neighbourhood in 9 cycles. One update cycle per cell follows.
// Iterations are Jacobi-style: every cell reads Ycur and writes Ynext, and a
// swap cycle then publishes the new outputs.
// Optional build macro CNN_CONVERGE_EN: a run also ends early when an
// iteration leaves every cell output unchanged.
module cnn_cell_engine #(
    parameter int WIDTH    = 9,
    parameter int FRAC     = 4,
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DT_SHIFT = 2,
    parameter int ADDR_W   = $clog2(ROWS * COLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9*WIDTH-1:0]   a_tmpl,
    input  logic [9*WIDTH-1:0]   b_tmpl,
    input  logic [WIDTH-1:0]     i_bias,
    input  logic [7:0]           iter_limit,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           iter_cnt,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    localparam int CELLS  = ROWS * COLS;
    localparam int PROD_W = 2 * WIDTH;
    localparam int ACC_W  = 2 * WIDTH + 4;
    localparam int DX_W   = ACC_W + 1;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic signed [WIDTH-1:0] Y_MAX = WIDTH'(1 << FRAC);
    localparam logic signed [WIDTH-1:0] Y_MIN = WIDTH'(-(1 << FRAC));
    localparam logic signed [DX_W-1:0]  X_MAX = DX_W'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [DX_W-1:0]  X_MIN = DX_W'(-(1 << (WIDTH - 1)));

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MAC    = 3'd1,
        ST_UPDATE = 3'd2,
        ST_SWAP   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Cell output nonlinearity: clamp to [-1.0, +1.0].
    function automatic logic signed [WIDTH-1:0] clamp_y(input logic signed [WIDTH-1:0] v);
        if (v > Y_MAX) begin
            return Y_MAX;
        end else if (v < Y_MIN) begin
            return Y_MIN;
        end else begin
            return v;
        end
    endfunction

    state_t                   state_r;
    logic signed [WIDTH-1:0]  u_r     [CELLS];
    logic signed [WIDTH-1:0]  x_r     [CELLS];
    logic signed [WIDTH-1:0]  ycur_r  [CELLS];
    logic signed [WIDTH-1:0]  ynext_r [CELLS];
    logic signed [WIDTH-1:0]  a_c_r   [9];
    logic signed [WIDTH-1:0]  b_c_r   [9];
    logic signed [WIDTH-1:0]  bias_r;
    logic [7:0]               lim_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic [3:0]               k_r;
    logic [RW-1:0]            row_r;
    logic [CW-1:0]            col_r;
    logic [ADDR_W-1:0]        cell_r;
`ifdef CNN_CONVERGE_EN
    logic                     changed_r;
`endif

    int                       nr_s;
    int                       nc_s;
    logic                     nb_ok_s;
    logic [ADDR_W-1:0]        nb_idx_s;
    logic signed [WIDTH-1:0]  y_nb_s;
    logic signed [WIDTH-1:0]  u_nb_s;
    logic signed [PROD_W-1:0] prod_a_s;
    logic signed [PROD_W-1:0] prod_b_s;
    logic signed [ACC_W-1:0]  mac_sum_s;

    logic signed [WIDTH-1:0]  x_cur_s;
    logic signed [ACC_W-1:0]  acc_fin_s;
    logic signed [DX_W-1:0]   dx_s;
    logic signed [DX_W-1:0]   step_s;
    logic signed [DX_W-1:0]   xsum_s;
    logic signed [WIDTH-1:0]  x_new_s;
    logic signed [WIDTH-1:0]  y_new_s;

    // Neighbour fetch for tap k of the current cell; off-grid taps read as zero.
    always_comb begin
        nr_s     = int'(row_r) + (int'(k_r) / 3) - 1;
        nc_s     = int'(col_r) + (int'(k_r) % 3) - 1;
        nb_ok_s  = (nr_s >= 0) && (nr_s < ROWS) && (nc_s >= 0) && (nc_s < COLS);
        nb_idx_s = '0;
        y_nb_s   = '0;
        u_nb_s   = '0;
        if (nb_ok_s) begin
            nb_idx_s = ADDR_W'(nr_s * COLS + nc_s);
            y_nb_s   = ycur_r[nb_idx_s];
            u_nb_s   = u_r[nb_idx_s];
        end else begin
            nb_idx_s = '0;
        end
        prod_a_s  = PROD_W'(a_c_r[k_r]) * PROD_W'(y_nb_s);
        prod_b_s  = PROD_W'(b_c_r[k_r]) * PROD_W'(u_nb_s);
        mac_sum_s = ACC_W'(prod_a_s) + ACC_W'(prod_b_s);
    end

    // Euler step for the current cell: add bias, form dx, scale by dt, saturate, clamp.
    always_comb begin
        x_cur_s   = x_r[cell_r];
        acc_fin_s = acc_r + (ACC_W'(bias_r) <<< FRAC);
        dx_s      = DX_W'(acc_fin_s) - (DX_W'(x_cur_s) <<< FRAC);
        step_s    = dx_s >>> (FRAC + DT_SHIFT);
        xsum_s    = DX_W'(x_cur_s) + step_s;
        x_new_s   = '0;
        if (xsum_s > X_MAX) begin
            x_new_s = X_MAX[WIDTH-1:0];
        end else if (xsum_s < X_MIN) begin
            x_new_s = X_MIN[WIDTH-1:0];
        end else begin
            x_new_s = xsum_s[WIDTH-1:0];
        end
        y_new_s = clamp_y(x_new_s);
    end

    // Control FSM plus all grid/template state; loads are accepted only when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            iter_cnt <= 8'd0;
            bias_r   <= '0;
            lim_r    <= 8'd0;
            acc_r    <= '0;
            k_r      <= 4'd0;
            row_r    <= '0;
            col_r    <= '0;
            cell_r   <= '0;
`ifdef CNN_CONVERGE_EN
            changed_r <= 1'b0;
`endif
            for (int i = 0; i < CELLS; i++) begin
                u_r[i]     <= '0;
                x_r[i]     <= '0;
                ycur_r[i]  <= '0;
                ynext_r[i] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                a_c_r[k] <= '0;
                b_c_r[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (wr_en) begin
                        if (wr_sel) begin
                            x_r[wr_addr]    <= wr_data;
                            ycur_r[wr_addr] <= clamp_y(wr_data);
                        end else begin
                            u_r[wr_addr] <= wr_data;
                        end
                    end
                    if (start) begin
                        for (int k = 0; k < 9; k++) begin
                            a_c_r[k] <= a_tmpl[k*WIDTH +: WIDTH];
                            b_c_r[k] <= b_tmpl[k*WIDTH +: WIDTH];
                        end
                        bias_r   <= i_bias;
                        lim_r    <= iter_limit;
                        iter_cnt <= 8'd0;
                        acc_r    <= '0;
                        k_r      <= 4'd0;
                        row_r    <= '0;
                        col_r    <= '0;
                        cell_r   <= '0;
`ifdef CNN_CONVERGE_EN
                        changed_r <= 1'b0;
`endif
                        if (iter_limit != 8'd0) begin
                            busy    <= 1'b1;
                            state_r <= ST_MAC;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_r + mac_sum_s;
                    if (k_r == 4'd8) begin
                        k_r     <= 4'd0;
                        state_r <= ST_UPDATE;
                    end else begin
                        k_r <= k_r + 4'd1;
                    end
                end
                ST_UPDATE: begin
                    x_r[cell_r]     <= x_new_s;
                    ynext_r[cell_r] <= y_new_s;
                    acc_r           <= '0;
`ifdef CNN_CONVERGE_EN
                    if (y_new_s != ycur_r[cell_r]) begin
                        changed_r <= 1'b1;
                    end
`endif
                    if (cell_r == ADDR_W'(CELLS - 1)) begin
                        cell_r  <= '0;
                        row_r   <= '0;
                        col_r   <= '0;
                        state_r <= ST_SWAP;
                    end else begin
                        cell_r <= cell_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (col_r == CW'(COLS - 1)) begin
                            col_r <= '0;
                            row_r <= row_r + {{(RW-1){1'b0}}, 1'b1};
                        end else begin
                            col_r <= col_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                        state_r <= ST_MAC;
                    end
                end
                ST_SWAP: begin
                    for (int i = 0; i < CELLS; i++) begin
                        ycur_r[i] <= ynext_r[i];
                    end
                    iter_cnt <= iter_cnt + 8'd1;
`ifdef CNN_CONVERGE_EN
                    changed_r <= 1'b0;
`endif
                    if (iter_cnt + 8'd1 == lim_r) begin
                        state_r <= ST_DONE;
`ifdef CNN_CONVERGE_EN
                    end else if (!changed_r) begin
                        state_r <= ST_DONE;
`endif
                    end else begin
                        state_r <= ST_MAC;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered Y readout; during a run this shows the last completed iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= ycur_r[rd_addr];
        end
    end

endmodule

// File: tb/tb_cnn_cell_engine.sv
// Directed bench for cnn_cell_engine (4x4 grid, WIDTH=9, FRAC=4, dt=1/4).
// Expected values are hand-computed fixed-point results.
module tb_cnn_cell_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [80:0] a_tmpl;
    logic [80:0] b_tmpl;
    logic [8:0]  i_bias;
    logic [7:0]  iter_limit;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  iter_cnt;
    logic [3:0]  rd_addr;
    logic [8:0]  rd_data;

    int          errors = 0;
    int          checks = 0;
    int          done_at;
    logic        busy_seen;
    logic [8:0]  yv;
    int          exp_cnt;
    int          exp_done;

    cnn_cell_engine dut (
        .clk        (clk),
        .rst        (rst),
        .a_tmpl     (a_tmpl),
        .b_tmpl     (b_tmpl),
        .i_bias     (i_bias),
        .iter_limit (iter_limit),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .iter_cnt   (iter_cnt),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cell(input logic sel, input int addr, input logic [8:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(addr);
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic fill_x(input logic [8:0] v);
        for (int i = 0; i < 16; i++) begin
            write_cell(1'b1, i, v);
        end
    endtask

    task automatic read_y(input int addr, output logic [8:0] v);
        rd_addr = 4'(addr);
        step();
        v = rd_data;
    endtask

    // Every cell equals def except cell sp_addr (if >= 0), which equals sp_val.
    task automatic check_grid(input string tag, input logic [8:0] def, input int sp_addr,
                              input logic [8:0] sp_val);
        logic [8:0] v;
        for (int i = 0; i < 16; i++) begin
            read_y(i, v);
            check($sformatf("%s_y%0d", tag, i), v, (i == sp_addr) ? sp_val : def);
        end
    endtask

    // Start a run; optionally poke start/wr_en at cycle poke_at, or rst at rst_at.
    // done_at is the cycle (counted from the start edge) where done was first seen, 0 if never.
    task automatic run(input int poke_at, input int rst_at, input int bound,
                       output int d_at, output logic b_seen);
        d_at   = 0;
        b_seen = 1'b0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        if (busy) b_seen = 1'b1;
        for (int n = 1; n <= bound; n++) begin
            if (n == poke_at) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'b1;
                wr_addr = 4'd0;
                wr_data = 9'h0F0;
            end
            if (n == rst_at) rst = 1'b1;
            step();
            start = 1'b0;
            wr_en = 1'b0;
            rst   = 1'b0;
            if (busy) b_seen = 1'b1;
            if (done) begin
                d_at = n;
                break;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        a_tmpl     = '0;
        b_tmpl     = '0;
        i_bias     = 9'h000;
        iter_limit = 8'd1;
        wr_en      = 1'b0;
        wr_sel     = 1'b0;
        wr_addr    = 4'd0;
        wr_data    = 9'h000;
        start      = 1'b0;
        rd_addr    = 4'd0;
        step();
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_iter", iter_cnt, 8'd0);
        check("rst_rd", rd_data, 9'h000);
        rst = 1'b0;
        step();
        check_grid("rst", 9'h000, -1, 9'h000);

        // Decay: X=1.0 everywhere, no inputs -> X'=0.75
        fill_x(9'h010);
        read_y(5, yv);
        check("load_clamp", yv, 9'h010);
        run(0, 0, 400, done_at, busy_seen);
        check("decay_done_cyc", done_at, 32'd162);
        check("decay_busy_seen", busy_seen, 1'b1);
        check("decay_busy_at_done", busy, 1'b0);
        check("decay_iter", iter_cnt, 8'd1);
        step();
        check("decay_done_pulse", done, 1'b0);
        check_grid("decay", 9'h00C, -1, 9'h000);

        // Mid-run start/write pokes are ignored
        fill_x(9'h010);
        run(40, 0, 400, done_at, busy_seen);
        check("ctrl_done_cyc", done_at, 32'd162);
        check("ctrl_iter", iter_cnt, 8'd1);
        check_grid("ctrl", 9'h00C, -1, 9'h000);

        // Saturation: I=5.0 from X=0 -> X'=1.25, Y clamped to 1.0
        fill_x(9'h000);
        i_bias = 9'h050;
        run(0, 0, 400, done_at, busy_seen);
        check("sat_done_cyc", done_at, 32'd162);
        check_grid("sat", 9'h010, -1, 9'h000);

        // Boundary: only B[0]=1.0, U(0,0)=1.0 -> only Y(1,1)=0.25
        i_bias = 9'h000;
        b_tmpl[8:0] = 9'h010;
        fill_x(9'h000);
        write_cell(1'b0, 0, 9'h010);
        run(0, 0, 400, done_at, busy_seen);
        check_grid("bnd", 9'h000, 5, 9'h004);

        // Reset at cycle 50 aborts the run
        run(0, 50, 400, done_at, busy_seen);
        check("rstmid_no_done", done_at, 32'd0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_iter", iter_cnt, 8'd0);
        check_grid("rstmid", 9'h000, -1, 9'h000);

        // iter_limit=0: done next cycle, never busy
        b_tmpl     = '0;
        iter_limit = 8'd0;
        run(0, 0, 10, done_at, busy_seen);
        check("zero_done_cyc", done_at, 32'd1);
        check("zero_busy_seen", busy_seen, 1'b0);
        check("zero_iter", iter_cnt, 8'd0);

        // Convergence: all-zero state, iter_limit=10
        iter_limit = 8'd10;
`ifdef CNN_CONVERGE_EN
        exp_cnt  = 1;
        exp_done = 162;
`else
        exp_cnt  = 10;
        exp_done = 1611;
`endif
        run(0, 0, 2000, done_at, busy_seen);
        check("conv_iter", iter_cnt, exp_cnt);
        check("conv_done_cyc", done_at, exp_done);

        // A centre=2.0 with signed X values, negative clamp and floor shift
        iter_limit     = 8'd1;
        a_tmpl[44:36]  = 9'h020;
        write_cell(1'b1, 0, 9'h008);
        write_cell(1'b1, 15, 9'h1F8);
        write_cell(1'b1, 3, 9'h1C0);
        write_cell(1'b1, 10, 9'h1FF);
        read_y(3, yv);
        check("neg_load_clamp", yv, 9'h1F0);
        run(0, 0, 400, done_at, busy_seen);
        read_y(0, yv);
        check("acen_y0", yv, 9'h00A);
        read_y(15, yv);
        check("acen_y15", yv, 9'h1F6);
        read_y(3, yv);
        check("acen_y3", yv, 9'h1F0);
        read_y(10, yv);
        check("acen_y10_floor", yv, 9'h1FE);
        read_y(5, yv);
        check("acen_y5", yv, 9'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
